// File: rtl/fxp_iter_mul_sat.sv
// Iterative fixed-point multiplier: K multiplier bits per cycle, early exit on
// leading zeros of |b|, floor rescale by 2^D and saturation with overflow flag.
module fxp_iter_mul_sat #(
  parameter int unsigned N = 8,
  parameter int unsigned D = 4,
  parameter int unsigned K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_en,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned AW = 2 * N + 1;

  // Rounding bias that turns a magnitude right-shift into a ceil (floor of the negated value)
  localparam logic [AW-1:0] RND       = (AW'(1) << D) - AW'(1);
  localparam logic [AW-1:0] S_MAX     = (AW'(1) << (N - 1)) - AW'(1);
  localparam logic [AW-1:0] U_MAX     = (AW'(1) << N) - AW'(1);
  localparam logic [AW-1:0] S_MIN_MAG = AW'(1) << (N - 1);
  localparam logic [N-1:0]  SAT_NEG   = {1'b1, {(N - 1){1'b0}}};
  localparam logic [N-1:0]  SAT_SPOS  = {1'b0, {(N - 1){1'b1}}};

  if (!((K == 1) || (K == 2) || (K == 4)) || ((N % K) != 0) || (N < 2) || (D > N)) begin : g_param_check
    $error("fxp_iter_mul_sat: illegal N/D/K combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [W2-1:0]  a_sh, a_sh_nxt;
  logic [N-1:0]   b_rem, b_rem_nxt;
  logic [W2-1:0]  acc, acc_nxt;
  logic           neg, neg_nxt;
  logic           sgn, sgn_nxt;
  logic           recv_rdy_nxt, send_val_nxt;
  logic [N-1:0]   c_nxt;
  logic           ovf_nxt;

  logic [N-1:0]   a_abs, b_abs;
  logic [W2-1:0]  sum;
  logic [AW-1:0]  q;
  logic [N-1:0]   c_res;
  logic           ovf_res;

  // N-bit magnitudes cover |-2^(N-1)| without overflow
  assign a_abs = (signed_en && a[N-1]) ? (~a + N'(1)) : a;
  assign b_abs = (signed_en && b[N-1]) ? (~b + N'(1)) : b;

  // One K-bit digit of |b| times the pre-shifted |a|
  assign sum = acc + a_sh * W2'(b_rem[K-1:0]);

  // Rescale the final magnitude and clamp to the signed/unsigned result range
  always_comb begin
    q       = ({1'b0, sum} + (neg ? RND : '0)) >> D;
    ovf_res = neg ? (q > S_MIN_MAG) : (q > (sgn ? S_MAX : U_MAX));
    if (ovf_res) begin
      c_res = neg ? SAT_NEG : (sgn ? SAT_SPOS : '1);
    end else begin
      c_res = neg ? N'(-q) : N'(q);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    a_sh_nxt  = a_sh;
    b_rem_nxt = b_rem;
    acc_nxt   = acc;
    neg_nxt   = neg;
    sgn_nxt   = sgn;
    c_nxt     = c;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (recv_val && recv_rdy) begin
          sgn_nxt   = signed_en;
          neg_nxt   = signed_en & (a[N-1] ^ b[N-1]);
          a_sh_nxt  = W2'(a_abs);
          b_rem_nxt = b_abs;
          acc_nxt   = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        acc_nxt   = sum;
        a_sh_nxt  = a_sh << K;
        b_rem_nxt = b_rem >> K;
        // Shifting out all N bits always empties b_rem, so this also bounds CALC to N/K cycles
        if ((b_rem >> K) == '0) begin
          state_nxt = DONE;
          c_nxt     = c_res;
          ovf_nxt   = ovf_res;
        end
      end
      DONE: begin
        if (send_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    recv_rdy_nxt = (state_nxt == IDLE);
    send_val_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_rem    <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      sgn      <= 1'b0;
      recv_rdy <= 1'b0;
      send_val <= 1'b0;
      c        <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      a_sh     <= a_sh_nxt;
      b_rem    <= b_rem_nxt;
      acc      <= acc_nxt;
      neg      <= neg_nxt;
      sgn      <= sgn_nxt;
      recv_rdy <= recv_rdy_nxt;
      send_val <= send_val_nxt;
      c        <= c_nxt;
      ovf      <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fxp_iter_mul_sat.sv
// Bench for fxp_iter_mul_sat: an N=8 D=4 K=1 instance and an N=8 D=0 K=2 instance
// checked against an integer-arithmetic reference model.
module tb_fxp_iter_mul_sat;

  logic       clk, rst_n;
  logic       rv0, rr0, sv0, sr0, se0, ov0;
  logic [7:0] a0, b0, c0;
  logic       rv1, rr1, sv1, sr1, se1, ov1;
  logic [7:0] a1, b1, c1;

  int n_cmp = 0;
  int n_err = 0;

  fxp_iter_mul_sat #(.N(8), .D(4), .K(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .recv_val(rv0), .recv_rdy(rr0), .a(a0), .b(b0),
    .signed_en(se0), .send_val(sv0), .send_rdy(sr0), .c(c0), .ovf(ov0)
  );

  fxp_iter_mul_sat #(.N(8), .D(0), .K(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .recv_val(rv1), .recv_rdy(rr1), .a(a1), .b(b1),
    .signed_en(se1), .send_val(sv1), .send_rdy(sr1), .c(c1), .ovf(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact product, floor by 2^d, clamp to range; latency from bit length of |b|
  function automatic void ref_model(input int d, input int k, input logic [7:0] aa,
                                    input logic [7:0] bb, input bit se,
                                    output logic [7:0] c_e, output bit ov_e, output int lat_e);
    longint av, bv, p, r, lo, hi, mag;
    int bl;
    av = se ? longint'($signed(aa)) : longint'(aa);
    bv = se ? longint'($signed(bb)) : longint'(bb);
    p  = av * bv;
    r  = p >>> d;
    lo = se ? -128 : 0;
    hi = se ? 127 : 255;
    if (r > hi) begin c_e = 8'(hi); ov_e = 1'b1; end
    else if (r < lo) begin c_e = 8'(lo); ov_e = 1'b1; end
    else begin c_e = 8'(r); ov_e = 1'b0; end
    mag = (bv < 0) ? -bv : bv;
    bl = 0;
    while (mag > 0) begin bl++; mag = mag >> 1; end
    lat_e = (bl + k - 1) / k;
    if (lat_e < 1) lat_e = 1;
  endfunction

  task automatic drive(input int dut, input logic v, input logic [7:0] aa,
                       input logic [7:0] bb, input logic s);
    if (dut == 0) begin rv0 = v; a0 = aa; b0 = bb; se0 = s; end
    else begin rv1 = v; a1 = aa; b1 = bb; se1 = s; end
  endtask

  task automatic set_srdy(input int dut, input logic v);
    if (dut == 0) sr0 = v; else sr1 = v;
  endtask

  function automatic logic get_rr(input int dut); return (dut == 0) ? rr0 : rr1; endfunction
  function automatic logic get_sv(input int dut); return (dut == 0) ? sv0 : sv1; endfunction
  function automatic logic [7:0] get_c(input int dut); return (dut == 0) ? c0 : c1; endfunction
  function automatic logic get_ov(input int dut); return (dut == 0) ? ov0 : ov1; endfunction

  // One full transaction; reports latency, result, and whether the send handshake closed cleanly
  task automatic do_txn(input int dut, input logic [7:0] aa, input logic [7:0] bb, input bit se,
                        input int hold, output int lat, output logic [7:0] cc, output bit ov,
                        output bit ok, output bit hs_ok);
    int w;
    ok = 1'b1; hs_ok = 1'b0; lat = 0; cc = '0; ov = 1'b0;
    w = 0;
    while (!get_rr(dut) && w < 20) begin @(posedge clk); #1; w++; end
    if (!get_rr(dut)) begin ok = 1'b0; return; end
    drive(dut, 1'b1, aa, bb, se);
    @(posedge clk); #1;
    drive(dut, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    do begin @(posedge clk); #1; lat++; end while (!get_sv(dut) && lat < 20);
    if (!get_sv(dut)) begin ok = 1'b0; return; end
    cc = get_c(dut);
    ov = get_ov(dut);
    for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
    set_srdy(dut, 1'b1);
    @(posedge clk); #1;
    set_srdy(dut, 1'b0);
    hs_ok = !get_sv(dut) && get_rr(dut);
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({rr0, sv0, c0, ov0, rr1, sv1, c1, ov1} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rr0=%b sv0=%b c0=%h ov0=%b rr1=%b sv1=%b c1=%h ov1=%b, want all 0",
               rr0, sv0, c0, ov0, rr1, sv1, c1, ov1);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (rr0 !== 1'b0) begin n_err++; $display("FAIL reset_rdy_before_edge: got %b want 0", rr0); end
    @(posedge clk); #1;
    n_cmp++;
    if (rr0 !== 1'b1 || rr1 !== 1'b1) begin
      n_err++; $display("FAIL reset_rdy_after_edge: got rr0=%b rr1=%b want 1 1", rr0, rr1);
    end
  endtask

  task automatic test_signed_basic;
    logic [7:0] ta[4] = '{8'h18, 8'hE8, 8'hFF, 8'h18};
    logic [7:0] tb[4] = '{8'h28, 8'h28, 8'h01, 8'h00};
    logic [7:0] tc[4] = '{8'h3C, 8'hC4, 8'hFF, 8'h00};
    int         tl[4] = '{6, 6, 1, 1};
    int lat; logic [7:0] cc; bit ov, ok, hs;
    for (int i = 0; i < 4; i++) begin
      do_txn(0, ta[i], tb[i], 1'b1, 0, lat, cc, ov, ok, hs);
      n_cmp++;
      if (!ok || !hs || cc !== tc[i] || ov !== 1'b0 || lat != tl[i]) begin
        n_err++;
        $display("FAIL signed_basic[%0d]: got ok=%b hs=%b c=%h ovf=%b lat=%0d want c=%h ovf=0 lat=%0d",
                 i, ok, hs, cc, ov, lat, tc[i], tl[i]);
      end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] ta[3] = '{8'h7F, 8'h80, 8'hFF};
    logic [7:0] tb[3] = '{8'h7F, 8'h7F, 8'hFF};
    bit         ts[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] tc[3] = '{8'h7F, 8'h80, 8'hFF};
    int         tl[3] = '{7, 7, 8};
    int lat; logic [7:0] cc; bit ov, ok, hs;
    for (int i = 0; i < 3; i++) begin
      do_txn(0, ta[i], tb[i], ts[i], 1, lat, cc, ov, ok, hs);
      n_cmp++;
      if (!ok || !hs || cc !== tc[i] || ov !== 1'b1 || lat != tl[i]) begin
        n_err++;
        $display("FAIL saturation[%0d]: got ok=%b hs=%b c=%h ovf=%b lat=%0d want c=%h ovf=1 lat=%0d",
                 i, ok, hs, cc, ov, lat, tc[i], tl[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int w;
    logic [7:0] cap_c; logic cap_ov;
    w = 0;
    while (!rr0 && w < 20) begin @(posedge clk); #1; w++; end
    drive(0, 1'b1, 8'h18, 8'h28, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    w = 0;
    while (!sv0 && w < 20) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (sv0 !== 1'b1 || c0 !== 8'h3C || ov0 !== 1'b0) begin
      n_err++; $display("FAIL bp_result: got sv=%b c=%h ovf=%b want 1 3c 0", sv0, c0, ov0);
    end
    cap_c = c0; cap_ov = ov0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk); #1;
      n_cmp++;
      if (sv0 !== 1'b1 || rr0 !== 1'b0 || c0 !== cap_c || ov0 !== cap_ov) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got sv=%b rr=%b c=%h ovf=%b want 1 0 %h %b",
                 i, sv0, rr0, c0, ov0, cap_c, cap_ov);
      end
    end
    // Send completes while recv_val is also high; the new request must not be taken
    drive(0, 1'b1, 8'h11, 8'h22, 1'b0);
    sr0 = 1'b1;
    @(posedge clk); #1;
    sr0 = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_cmp++;
    if (sv0 !== 1'b0 || rr0 !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got sv=%b rr=%b want 0 1", sv0, rr0);
    end
  endtask

  task automatic test_k2;
    logic [7:0] tb[2] = '{8'hC3, 8'h03};
    logic [7:0] tc[2] = '{8'hFF, 8'h1E};
    bit         to[2] = '{1'b1, 1'b0};
    int         tl[2] = '{4, 1};
    int lat; logic [7:0] cc; bit ov, ok, hs;
    for (int i = 0; i < 2; i++) begin
      do_txn(1, 8'h0A, tb[i], 1'b0, 0, lat, cc, ov, ok, hs);
      n_cmp++;
      if (!ok || !hs || cc !== tc[i] || ov !== to[i] || lat != tl[i]) begin
        n_err++;
        $display("FAIL k2[%0d]: got ok=%b hs=%b c=%h ovf=%b lat=%0d want c=%h ovf=%b lat=%0d",
                 i, ok, hs, cc, ov, lat, tc[i], to[i], tl[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int w, lat; logic [7:0] cc, ce; bit ov, ok, hs, oe; int le;
    w = 0;
    while (!rr0 && w < 20) begin @(posedge clk); #1; w++; end
    drive(0, 1'b1, 8'h55, 8'hFF, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sv0 !== 1'b0 || c0 !== 8'h00 || ov0 !== 1'b0 || rr0 !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: got sv=%b c=%h ovf=%b rr=%b want all 0", sv0, c0, ov0, rr0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (rr0 !== 1'b0 || sv0 !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_release: got rr=%b sv=%b want 0 0", rr0, sv0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rr0 !== 1'b1) begin n_err++; $display("FAIL reset_mid_rdy: got %b want 1", rr0); end
    ref_model(4, 1, 8'hD3, 8'h35, 1'b1, ce, oe, le);
    do_txn(0, 8'hD3, 8'h35, 1'b1, 0, lat, cc, ov, ok, hs);
    n_cmp++;
    if (!ok || !hs || cc !== ce || ov !== oe || lat != le) begin
      n_err++;
      $display("FAIL reset_mid_next: got ok=%b hs=%b c=%h ovf=%b lat=%0d want c=%h ovf=%b lat=%0d",
               ok, hs, cc, ov, lat, ce, oe, le);
    end
  endtask

  task automatic test_random;
    int lat, le, dut, hold;
    logic [7:0] aa, bb, cc, ce;
    bit se, ov, ok, hs, oe;
    for (int i = 0; i < 80; i++) begin
      dut  = i % 2;
      aa   = 8'($urandom);
      bb   = (i % 7 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      se   = 1'($urandom);
      hold = $urandom_range(0, 2);
      if (dut == 0) ref_model(4, 1, aa, bb, se, ce, oe, le);
      else          ref_model(0, 2, aa, bb, se, ce, oe, le);
      do_txn(dut, aa, bb, se, hold, lat, cc, ov, ok, hs);
      n_cmp++;
      if (!ok || !hs || cc !== ce || ov !== oe || lat != le) begin
        n_err++;
        $display("FAIL random[%0d] dut%0d a=%h b=%h s=%b: got ok=%b hs=%b c=%h ovf=%b lat=%0d want c=%h ovf=%b lat=%0d",
                 i, dut, aa, bb, se, ok, hs, cc, ov, lat, ce, oe, le);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rv0 = 1'b0; a0 = '0; b0 = '0; se0 = 1'b0; sr0 = 1'b0;
    rv1 = 1'b0; a1 = '0; b1 = '0; se1 = 1'b0; sr1 = 1'b0;
    test_reset();
    test_signed_basic();
    test_saturation();
    test_backpressure();
    test_k2();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fxp_iter_mul_sat.md
Name: fxp_iter_mul_sat

Overview:
- Parametrised iterative fixed-point multiplier with val/rdy handshakes on both sides.
- Successor to the fixed 6-bit iterative multiplier. Adds:
  - configurable width and fraction bits;
  - per-transaction signed/unsigned mode;
  - K bits of multiplier per cycle;
  - early termination on leading zeros;
  - saturation with an overflow flag.
- Sits between the top-level pin adapter and the GPIO outputs, one transaction at a time.

Parameters:
- N, 8, operand and result width in bits (N >= 2).
- D, 4, fractional bits of a, b and c (0 <= D <= N).
- K, 1, multiplier bits consumed per CALC cycle. Allowed values are 1, 2 and 4, and N % K == 0. Any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- recv_val  in  1  operands valid
- recv_rdy  out  1  block can accept operands
- a  in  N  multiplicand, fixed-point with D fraction bits
- b  in  N  multiplier, fixed-point with D fraction bits
- signed_en  in  1  1 = two's-complement operands and result, 0 = unsigned; sampled with a/b
- send_val  out  1  result valid
- send_rdy  in  1  consumer ready
- c  out  N  result, fixed-point with D fraction bits
- ovf  out  1  result was saturated; valid while send_val is high

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; recv_rdy = 0; send_val = 0; c = 0; ovf = 0; all datapath registers cleared.
  - recv_rdy is registered. It rises on the first rising edge after rst_n goes high.
- States and transitions:
  - IDLE: recv_rdy = 1, send_val = 0. On an edge with recv_val & recv_rdy:
    - latch signed_en, |a|, |b| and the sign of the product (sa ^ sb when signed, else 0);
    - clear the accumulator; go to CALC; recv_rdy drops to 0.
  - CALC: each edge adds |a| * (low K bits of remaining |b|) << (K*digit) to the 2N-bit accumulator, then shifts the remaining |b| right by K.
    - Leave CALC after the edge on which the remaining |b| becomes 0 or N/K digits have been processed, whichever comes first.
    - CALC always lasts at least 1 cycle, so b = 0 takes 1 cycle.
    - Latency from the accept edge to send_val high = max(1, ceil(bitlen(|b|)/K)) cycles. Maximum is N/K.
  - DONE: send_val = 1; c and ovf are registered and held stable until send_rdy.
    - On the edge with send_val & send_rdy: go to IDLE, send_val = 0, recv_rdy = 1 after that edge.
    - There is no overlap: a new accept happens at the earliest one cycle after the send handshake.
- Inputs ignored:
  - recv_val is ignored outside IDLE.
  - a, b and signed_en are ignored except on the accept edge.
  - send_rdy is ignored outside DONE.
- Arithmetic:
  - Exact product P = A * B, where A and B are the operands interpreted per signed_en.
  - R = floor(P / 2^D). For negative P this is an arithmetic shift, rounding toward minus infinity.
  - Range is [-2^(N-1), 2^(N-1)-1] when signed, [0, 2^N-1] when unsigned.
  - If R is in range: c = R[N-1:0], ovf = 0.
  - Otherwise c saturates to the nearest bound (signed max 0x7F.., signed min 0x80.., unsigned max all-ones) and ovf = 1.
  - The signed corner case |-2^(N-1)| is handled with N-bit unsigned magnitudes; no overflow occurs internally.
- Reset mid-operation (any state): abort immediately to reset values; the partial result is discarded and never presented.
- Simultaneous recv_val and send_rdy in DONE: only the send completes; recv_val is not accepted.

Test Plan:
- Signed, N=8 D=4 K=1: a=0x18, b=0x28, recv_val pulse, send_rdy=1 -> send_val rises 6 cycles after accept; c=0x3C, ovf=0.
- Signed negative floor: a=0xE8, b=0x28 -> c=0xC4. Then a=0xFF, b=0x01 -> c=0xFF (floor of -1/16), ovf=0. Then b=0x00 -> latency 1, c=0x00.
- Saturation:
  - signed a=0x7F, b=0x7F -> c=0x7F, ovf=1;
  - signed a=0x80, b=0x7F -> c=0x80, ovf=1;
  - unsigned a=0xFF, b=0xFF -> c=0xFF, ovf=1.
- Backpressure: send_rdy=0 for 5 cycles after send_val -> c and ovf stable, recv_rdy=0, toggling recv_val and a/b has no effect. Raise send_rdy -> one handshake, recv_rdy=1 the next cycle.
- K=2 build, N=8 D=0 unsigned: a=0x0A, b=0xC3 -> latency 4, c saturates to 0xFF with ovf=1 (product 1950). Then b=0x03 -> latency 1, c=0x1E.
- Reset: assert rst_n low during the 3rd CALC cycle -> send_val, c, ovf = 0 and recv_rdy = 0 immediately. After release, recv_rdy = 1 on the next edge; the next transaction gives a correct result.
